instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encoder counterpart to the core's opcode/funct control decoder.
- Accepts one symbolic instruction per handshake (mnemonic code, register fields, immediate, shamt) and packs it into a 32-bit MIPS word.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory through a valid/ready write port.
- Used by the test/boot loader to fill instruction memory for the single-cycle datapath.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2).
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ADDI, 8 ANDI, 9 ORI, 10 XORI, 11 LUI, 12 LW, 13 SW, 14–15 illegal.
- in_rd / in_rs / in_rt  in  5 each  register fields.
- in_shamt  in  5  shift amount (SLL/SRL only).
- in_imm  in  16  immediate (I-type only).
- mem_we  out  1  write request valid.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  encoded instruction word.
- err  out  1  sticky flag: an illegal in_op was accepted.
- words  out  ADDR_W+1  number of words written; saturates at all-ones.

Behaviour:
- Reset (sync, any time, including mid-transfer):
  - FIFO emptied; mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR.
  - err=0, words=0, in_ready=1 on the next cycle.
  - Pending requests are discarded.
- Input handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (FIFO occupancy < DEPTH). It is combinational from registered occupancy, never from mem_ready, so a pop in the same cycle does not free a slot while full.
- Encoding (combinational, registered into the FIFO on accept):
  - R-type = {6'b000000, rs, rt, rd, shamt, funct}, funct: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010.
  - SLL/SRL: rs field forced to 0. Other R-type ops: shamt forced to 0.
  - I-type = {opcode, rs, rt, imm}, opcode: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LUI 001111 (rs forced 0), LW 100011, SW 101011.
  - in_rd is ignored for I-type.
- Illegal op (14, 15): handshake completes, nothing is pushed, err set on the same edge and held until rst.
- Latency: a word accepted at edge N appears on mem_wdata/mem_we from the cycle after N if the FIFO was empty; otherwise it waits behind older entries. Order is strictly FIFO.
- Output port:
  - mem_we = FIFO non-empty; mem_wdata/mem_addr are the head entry and current address.
  - A write completes on an edge with mem_we && mem_ready: pop head, mem_addr += 1, words += 1 (saturating).
  - mem_wdata and mem_addr hold stable while mem_we && !mem_ready.
- Simultaneous push and pop when not full: occupancy unchanged, both take effect.
- Address wrap: mem_addr wraps from 2^ADDR_W−1 to 0 with no flag. words continues counting.
- FIFO pointers: log2(DEPTH) bits each, wrap naturally; occupancy counter is log2(DEPTH)+1 bits.

Test Plan:
- ADD rd=3 rs=1 rt=2, mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820; words=1 after the write.
- Sequence ADDI rt=5 rs=0 imm=0x0010; LUI rt=1 imm=0x1234 (rs=7 given); SLL rd=4 rt=2 shamt=3 (rs=9 given) → 0x20050010 @0, 0x3C011234 @1, 0x000220C0 @2.
- mem_ready=0, push 5 requests back-to-back → 4 accepted, in_ready=0 from the cycle after the 4th. Raise mem_ready → words written in order to addr 0..3, 5th accepted once a slot frees.
- LW rt=8 rs=29 imm=4 then SW with the same fields → 0x8FA80004, 0xAFA80004. Then in_op=14 → accepted, err=1, no write, mem_addr unchanged at 2.
- ADDR_W=2: write 5 words → addresses 0,1,2,3,0; words=5.
- Assert rst with 3 words buffered and mem_ready=0 → next cycle mem_we=0, mem_addr=BASE_ADDR, err=0, words=0, in_ready=1. A following ADD is written at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// instruction memory through a small FIFO and a valid/ready write port.
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [ADDR_W:0]   words
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]       FULL     = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0]     PTR_ONE  = 1;
    localparam logic [PW:0]       CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   WORD_ONE = 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW
    } op_e;

    logic [31:0]   fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   enc_word;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Shifts take their operand from rt, so rs is zeroed; other R-types zero shamt.
    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100000);
            OP_SUB:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100010);
            OP_AND:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100100);
            OP_OR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100101);
            OP_XOR:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'b100110);
            OP_SLL:  enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'b000000);
            OP_SRL:  enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'b000010);
            OP_ADDI: enc_word = i_word(6'b001000, in_rs, in_rt, in_imm);
            OP_ANDI: enc_word = i_word(6'b001100, in_rs, in_rt, in_imm);
            OP_ORI:  enc_word = i_word(6'b001101, in_rs, in_rt, in_imm);
            OP_XORI: enc_word = i_word(6'b001110, in_rs, in_rt, in_imm);
            OP_LUI:  enc_word = i_word(6'b001111, 5'd0, in_rt, in_imm);
            OP_LW:   enc_word = i_word(6'b100011, in_rs, in_rt, in_imm);
            OP_SW:   enc_word = i_word(6'b101011, in_rs, in_rt, in_imm);
            default: legal = 1'b0;
        endcase
    end

    // Readiness comes only from registered occupancy, so a full FIFO stays
    // closed for the cycle in which its head is being popped.
    assign in_ready  = (count < FULL);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign mem_we    = (count != '0);
    assign pop       = mem_we && mem_ready;
    assign mem_wdata = mem_we ? fifo[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_addr <= BASE;
            words    <= '0;
            err      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                mem_addr <= mem_addr + ADDR_ONE;
                if (words != '1) begin
                    words <= words + WORD_ONE;
                end
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
